// File: rtl/cafeteria_id_checker.sv
// Fresh-ID checker: stores sorted, disjoint inclusive ranges from a load stream,
// then answers streamed ID queries by binary search and counts the fresh IDs.
module cafeteria_id_checker #(
  parameter int unsigned WIDTH      = 50,
  parameter int unsigned MAX_RANGES = 256,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned CNT_W      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_start,
  input  logic [WIDTH-1:0] load_end,
  input  logic             load_last,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [WIDTH-1:0] q_id,
  input  logic             q_last,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_fresh,
  output logic [WIDTH-1:0] r_id,
  output logic [IDX_W:0]   num_ranges,
  output logic [CNT_W-1:0] fresh_count,
  output logic             order_err,
  output logic             overflow,
  output logic             finished
);

  typedef enum logic [2:0] {StIdle, StLoad, StQidle, StSearch, StResp, StDone} state_e;

  localparam logic [IDX_W:0]          FullCount = (IDX_W+1)'(MAX_RANGES);
  localparam logic [IDX_W:0]          CountOne  = (IDX_W+1)'(1);
  localparam logic signed [IDX_W+1:0] One       = (IDX_W+2)'(1);

  state_e state_q;

  logic [WIDTH-1:0] start_mem [MAX_RANGES];
  logic [WIDTH-1:0] end_mem   [MAX_RANGES];

  logic [WIDTH-1:0]        last_end_q;
  logic                    last_q;
  logic signed [IDX_W+1:0] lo_q, hi_q;

  logic                    table_full;
  logic                    order_bad;
  logic signed [IDX_W+1:0] sum, mid, mid_dec, mid_inc, hi_init;
  logic [IDX_W-1:0]        mid_idx;
  logic                    store_beat;

  // Handshake flags decode straight from the state register.
  assign load_ready = (state_q == StLoad);
  assign q_ready    = (state_q == StQidle);
  assign r_valid    = (state_q == StResp);
  assign finished   = (state_q == StDone);

  assign table_full = (num_ranges == FullCount);
  assign order_bad  = (load_end < load_start) ||
                      ((num_ranges != '0) && (load_start <= last_end_q));
  assign store_beat = load_ready && load_valid && !table_full;

  // lo and hi stay non-negative while searching, so the shift never sees a sign bit.
  assign sum     = lo_q + hi_q;
  assign mid     = sum >>> 1;
  assign mid_idx = mid[IDX_W-1:0];
  assign mid_dec = mid - One;
  assign mid_inc = mid + One;
  assign hi_init = $signed({1'b0, num_ranges}) - One;

  // Range table write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (store_beat) begin
      start_mem[num_ranges[IDX_W-1:0]] <= load_start;
      end_mem[num_ranges[IDX_W-1:0]]   <= load_end;
    end
  end

  // Main control FSM with counters, sticky flags and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      num_ranges  <= '0;
      fresh_count <= '0;
      order_err   <= 1'b0;
      overflow    <= 1'b0;
      r_fresh     <= 1'b0;
      r_id        <= '0;
      last_end_q  <= '0;
      last_q      <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StLoad;
            num_ranges  <= '0;
            fresh_count <= '0;
            order_err   <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        StLoad: begin
          if (load_valid) begin
            if (order_bad) order_err <= 1'b1;
            // A full table drops the beat but still completes the handshake.
            if (table_full) begin
              overflow <= 1'b1;
            end else begin
              num_ranges <= num_ranges + CountOne;
              last_end_q <= load_end;
            end
            if (load_last) state_q <= StQidle;
          end
        end
        StQidle: begin
          if (q_valid) begin
            r_id    <= q_id;
            last_q  <= q_last;
            r_fresh <= 1'b0;
            lo_q    <= '0;
            hi_q    <= hi_init;
            state_q <= (num_ranges == '0) ? StResp : StSearch;
          end
        end
        StSearch: begin
          if (r_id < start_mem[mid_idx]) begin
            hi_q <= mid_dec;
            if (lo_q > mid_dec) state_q <= StResp;
          end else if (r_id > end_mem[mid_idx]) begin
            lo_q <= mid_inc;
            if (mid_inc > hi_q) state_q <= StResp;
          end else begin
            r_fresh <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (r_ready) begin
            fresh_count <= fresh_count + CNT_W'(r_fresh);
            state_q     <= last_q ? StDone : StQidle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
